// File: rtl/line_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_pkg
// Description : Shared constants, width helpers and types for line_window_buf.
// Revision    : 1.0 - initial release
// ============================================================================
package line_buf_pkg;

  localparam int LINES_MAX = 8;

  // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int col_w(input int len_max);
    return clog2(len_max);
  endfunction

  function automatic int len_w(input int len_max);
    return clog2(len_max) + 1;
  endfunction

  localparam int LINE_IDX_W = clog2(LINES_MAX);

  // Wide enough for both the ring index and the rows-filled count.
  typedef logic [LINE_IDX_W-1:0] line_idx_t;

endpackage
`default_nettype wire

// File: rtl/line_ram_rf.sv
`default_nettype none
// ============================================================================
// Module      : line_ram_rf
// Description : Simple dual-port, read-first, registered-read line RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module line_ram_rf
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // No reset so the array stays inferable as block RAM; old data is read
  // out before the same-address write lands.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/line_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_window_buf
// Description : Multi-line window buffer emitting a vertical pixel column
//               (current pixel plus LINES-1 previous lines) per input pixel.
//               Define LINE_BUF_BORDER_REPLICATE_EN to replicate the current
//               pixel into unfilled rows instead of zero padding.
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_buf
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 1,
  parameter int LINES        = 3,
  parameter int LINE_LEN_MAX = 2048
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [clog2(LINE_LEN_MAX):0]  line_len,
  input  logic                          sof,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  output logic [LINES*DATA_WIDTH-1:0]   out_col,
  output logic [clog2(LINE_LEN_MAX)-1:0] out_col_idx,
  output logic                          out_rows_ok
);

  localparam int        c_col_w     = col_w(LINE_LEN_MAX);
  localparam int        c_len_w     = len_w(LINE_LEN_MAX);
  localparam int        c_nlines    = LINES - 1;
  localparam line_idx_t c_last_line = line_idx_t'(LINES - 2);
  localparam line_idx_t c_full      = line_idx_t'(LINES - 1);

  // Input-side counters
  logic [c_col_w-1:0] r_col;
  logic [c_len_w-1:0] r_len;
  line_idx_t          r_wr_line;
  line_idx_t          r_rows_filled;

  // Output-side snapshot of the accepted pixel
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_cur;
  logic [c_col_w-1:0]    r_out_col_idx;
  line_idx_t             r_rows_q;
  line_idx_t             r_wr_q;

  logic [c_col_w-1:0]    w_col;
  logic [c_len_w-1:0]    w_len;
  line_idx_t             w_wr_line;
  line_idx_t             w_rows;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_rd [c_nlines];
  logic [LINES*DATA_WIDTH-1:0] w_col_out;

  // A start-of-frame pixel overrides all counter state, so every decision
  // below works on these effective values rather than the raw registers.
  always_comb begin
    w_col     = sof ? '0 : r_col;
    w_len     = sof ? line_len : r_len;
    w_wr_line = sof ? '0 : r_wr_line;
    w_rows    = sof ? '0 : r_rows_filled;
    w_last    = ({1'b0, w_col} == (w_len - c_len_w'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col         <= '0;
      r_len         <= c_len_w'(LINE_LEN_MAX);
      r_wr_line     <= '0;
      r_rows_filled <= '0;
    end else if (in_valid) begin
      r_len <= w_len;
      if (w_last) begin
        r_col         <= '0;
        r_wr_line     <= (w_wr_line == c_last_line) ? '0 : w_wr_line + 1'b1;
        r_rows_filled <= (w_rows == c_full) ? w_rows : w_rows + 1'b1;
      end else begin
        r_col         <= w_col + 1'b1;
        r_wr_line     <= w_wr_line;
        r_rows_filled <= w_rows;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_cur         <= '0;
      r_out_col_idx <= '0;
      r_rows_q      <= '0;
      r_wr_q        <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_cur         <= in_data;
        r_out_col_idx <= w_col;
        r_rows_q      <= w_rows;
        r_wr_q        <= w_wr_line;
      end
    end
  end

  for (genvar g = 0; g < c_nlines; g++) begin : g_line
    line_ram_rf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (LINE_LEN_MAX),
      .ADDR_W     (c_col_w)
    ) u_ram (
      .clk     (clk),
      .i_we    (in_valid && (w_wr_line == line_idx_t'(g))),
      .i_waddr (w_col),
      .i_wdata (in_data),
      .i_re    (in_valid),
      .i_raddr (w_col),
      .o_rdata (w_rd[g])
    );
  end

  // Slice k (k>=1) is k lines old: it lives LINES-1-k ring steps past the
  // oldest line, which is the one that was being overwritten.
  always_comb begin
    int                    v_idx;
    logic [DATA_WIDTH-1:0] v_sel;
    v_idx     = 0;
    v_sel     = '0;
    w_col_out = '0;
    w_col_out[DATA_WIDTH-1:0] = r_cur;
    for (int k = 1; k < LINES; k++) begin
      v_idx = int'(r_wr_q) + c_nlines - k;
      if (v_idx >= c_nlines) v_idx = v_idx - c_nlines;
      v_sel = '0;
      for (int j = 0; j < c_nlines; j++) begin
        if (j == v_idx) v_sel = w_rd[j];
      end
      if (k <= int'(r_rows_q)) begin
        w_col_out[k*DATA_WIDTH +: DATA_WIDTH] = v_sel;
      end else begin
`ifdef LINE_BUF_BORDER_REPLICATE_EN
        w_col_out[k*DATA_WIDTH +: DATA_WIDTH] = r_cur;
`else
        w_col_out[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_col     = w_col_out;
  assign out_col_idx = r_out_col_idx;
  assign out_rows_ok = (r_rows_q == c_full);

endmodule
`default_nettype wire

// File: tb/tb_line_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_window_buf
// Description : Directed self-checking bench for line_window_buf (LINES=3 and
//               LINES=5 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // LINES=3, LINE_LEN_MAX=16 instance
  logic [4:0]  line_len;
  logic        sof;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [23:0] out_col;
  logic [3:0]  out_col_idx;
  logic        out_rows_ok;

  // LINES=5, LINE_LEN_MAX=2048 instance
  logic [11:0] line_len5;
  logic        sof5;
  logic        in_valid5;
  logic [7:0]  in_data5;
  logic        out_valid5;
  logic [39:0] out_col5;
  logic [10:0] out_col_idx5;
  logic        out_rows_ok5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  line_window_buf #(.DATA_WIDTH(8), .LINES(3), .LINE_LEN_MAX(16)) u_dut (
    .clk(clk), .rst(rst), .line_len(line_len), .sof(sof), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_col(out_col),
    .out_col_idx(out_col_idx), .out_rows_ok(out_rows_ok)
  );

  line_window_buf #(.DATA_WIDTH(8), .LINES(5), .LINE_LEN_MAX(2048)) u_dut5 (
    .clk(clk), .rst(rst), .line_len(line_len5), .sof(sof5), .in_valid(in_valid5),
    .in_data(in_data5), .out_valid(out_valid5), .out_col(out_col5),
    .out_col_idx(out_col_idx5), .out_rows_ok(out_rows_ok5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic [23:0] ecol,
                          input logic [3:0] eidx, input logic eok);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_col"}, 64'(out_col), 64'(ecol));
    check({tag, "_idx"}, 64'(out_col_idx), 64'(eidx));
    check({tag, "_ok"}, 64'(out_rows_ok), 64'(eok));
  endtask

  // Expected LINES=3 column for pixel p in row r of a line_len=4 ramp.
  function automatic logic [23:0] exp3(input int r, input logic [7:0] p);
    logic [7:0] s2, s1;
    s2 = (r >= 2) ? p - 8'd8 : 8'h00;
    s1 = (r >= 1) ? p - 8'd4 : 8'h00;
    return {s2, s1, p};
  endfunction

  function automatic logic [7:0] f5(input int r, input int c);
    return 8'(c) ^ 8'(r * 37);
  endfunction

  task automatic push(input logic s, input logic [7:0] d);
    @(negedge clk);
    sof = s; in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    sof = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push5(input logic s, input logic [7:0] d);
    @(negedge clk);
    sof5 = s; in_valid5 = 1'b1; in_data5 = d;
    @(posedge clk); #1;
    sof5 = 1'b0; in_valid5 = 1'b0;
  endtask

  initial begin
    logic [39:0] e5;
    line_len = 5'd4; sof = 1'b0; in_valid = 1'b0; in_data = '0;
    line_len5 = 12'd2048; sof5 = 1'b0; in_valid5 = 1'b0; in_data5 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_col", 64'(out_col), 64'(0));
    check("rst_idx", 64'(out_col_idx), 64'(0));
    check("rst_ok", 64'(out_rows_ok), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Continuous 0x01..0x0C stream; line_len change without sof is ignored
    for (int i = 0; i < 12; i++) begin
      push(i == 0, 8'(i + 1));
      if (i == 0) line_len = 5'd2;
      check_px("t1", exp3(i / 4, 8'(i + 1)), 4'(i % 4), (i / 4) >= 2);
    end

    // Same stream with a gap after every pixel
    line_len = 5'd4;
    for (int i = 0; i < 12; i++) begin
      push(i == 0, 8'(i + 1));
      check_px("t2", exp3(i / 4, 8'(i + 1)), 4'(i % 4), (i / 4) >= 2);
      idle();
      check("t2_gap_valid", 64'(out_valid), 64'(0));
    end

    // New frame begun mid-line at col 2 of row 1
    for (int i = 0; i < 6; i++) push(i == 0, 8'(8'h11 + i));
    check_px("t3_pre", {8'h00, 8'h12, 8'h16}, 4'd1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      push(i == 0, 8'(8'h20 + i));
      check_px("t3", exp3(i / 4, 8'(8'h20 + i)), 4'(i % 4), (i / 4) >= 2);
    end

    // Asynchronous reset mid-line 2
    push(1'b0, 8'h29);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'(0));
    check("t5_rst_col", 64'(out_col), 64'(0));
    check("t5_rst_idx", 64'(out_col_idx), 64'(0));
    check("t5_rst_ok", 64'(out_rows_ok), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 8'h40);
    check_px("t5_first", {8'h00, 8'h00, 8'h40}, 4'd0, 1'b0);
    for (int i = 1; i < 16; i++) push(1'b0, 8'(8'h40 + i));
    check("t5_last_idx", 64'(out_col_idx), 64'(15));
    push(1'b0, 8'h50);
    check_px("t5_wrap", {8'h00, 8'h40, 8'h50}, 4'd0, 1'b0);

    // LINES=5, full 2048-pixel lines, six lines so the ring wraps
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 2048; c++) begin
        push5((r == 0) && (c == 0), f5(r, c));
        if (c == 0 || c == 1 || c == 1023 || c == 2047) begin
          e5 = '0;
          for (int k = 0; k < 5; k++)
            if (r >= k) e5[k*8 +: 8] = f5(r - k, c);
          check("t4_valid", 64'(out_valid5), 64'(1));
          check("t4_col", 64'(out_col5), 64'(e5));
          check("t4_idx", 64'(out_col_idx5), 64'(c));
          check("t4_ok", 64'(out_rows_ok5), 64'(r >= 4));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
